// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared encodings for the FP issue controller: op codes, FSM states and latency-load helper.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        FP_ADD = 2'b00,
        FP_SUB = 2'b01,
        FP_MUL = 2'b10,
        FP_DIV = 2'b11
    } fp_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_RSVD = 2'd3
    } fsm_state_e;

    // Div loads the full timeout; fixed-latency ops load LAT-1 since the issue cycle counts.
    function automatic int unsigned lat_load(fp_op_e op, int unsigned add_lat,
                                             int unsigned mul_lat, int unsigned div_tmo);
        case (op)
            FP_MUL:  return mul_lat - 1;
            FP_DIV:  return div_tmo;
            default: return add_lat - 1;
        endcase
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Pipeline/hazard-unit and FP-unit handshake signals seen by the FP issue controller.
interface fpu_issue_ctrl_if;

    logic       fp_validE;
    logic [1:0] fp_opE;
    logic       flushE;
    logic       mem_stall;
    logic       fpu_done;
    logic       fpu_start;
    logic [1:0] fpu_op;
    logic       fp_stall;
    logic       fp_res_we;
    logic       fpu_busy;
    logic       fp_timeout;

    modport master (
        input  fp_validE, fp_opE, flushE, mem_stall, fpu_done,
        output fpu_start, fpu_op, fp_stall, fp_res_we, fpu_busy, fp_timeout
    );

    modport slave (
        output fp_validE, fp_opE, flushE, mem_stall, fpu_done,
        input  fpu_start, fpu_op, fp_stall, fp_res_we, fpu_busy, fp_timeout
    );

endinterface

// File: rtl/fpu_lat_cnt.sv
// Load/decrement latency counter; is_one flags the last RUN cycle.
module fpu_lat_cnt #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequences the multi-cycle FP unit in Execute: launch, pipeline hold, and result capture.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned ADD_LAT = 3,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_TMO = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    fpu_issue_ctrl_if.master  bus
);

    fsm_state_e       state_q, state_d;
    fp_op_e           fpu_op_q, fpu_op_d;
    logic             idle, iss, is_div, cnt_is_one;
    logic [CNT_W-1:0] cnt_load_val;

    // The reserved encoding behaves exactly like IDLE.
    assign idle   = (state_q != S_RUN) && (state_q != S_DONE);
    assign iss    = idle && bus.fp_validE && !bus.flushE && !bus.mem_stall;
    assign is_div = (fpu_op_q == FP_DIV);

    assign cnt_load_val = CNT_W'(lat_load(fp_op_e'(bus.fp_opE), ADD_LAT, MUL_LAT, DIV_TMO));

    fpu_lat_cnt #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (iss),
        .load_val_i (cnt_load_val),
        .dec_i      (state_q == S_RUN),
        .is_one_o   (cnt_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fpu_op_q <= FP_ADD;
        end else begin
            state_q  <= state_d;
            fpu_op_q <= fpu_op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fpu_op_d = fpu_op_q;
        case (state_q)
            S_RUN: begin
                if (cnt_is_one || (is_div && bus.fpu_done)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.mem_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (iss) begin
                    state_d  = S_RUN;
                    fpu_op_d = fp_op_e'(bus.fp_opE);
                end
            end
        endcase
    end

    always_comb begin
        bus.fpu_start  = iss;
        bus.fp_stall   = iss;
        bus.fp_res_we  = 1'b0;
        bus.fp_timeout = 1'b0;
        bus.fpu_busy   = !idle;
        case (state_q)
            S_RUN: begin
                bus.fp_stall   = 1'b1;
                // A done arriving on the last count is a normal completion.
                bus.fp_timeout = is_div && cnt_is_one && !bus.fpu_done;
            end
            S_DONE: begin
                bus.fp_res_we = !bus.mem_stall;
            end
            default: ;
        endcase
    end

    assign bus.fpu_op = fpu_op_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios plus random traffic against an elapsed-time model.
module tb_fpu_issue_ctrl;
    import fpu_ctrl_pkg::*;

    localparam int ADD_LAT = 3;
    localparam int MUL_LAT = 4;
    localparam int DIV_TMO = 64;

    logic clk = 1'b0;
    logic rst;
    fpu_issue_ctrl_if bus();

    fpu_issue_ctrl #(
        .ADD_LAT (ADD_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_TMO (DIV_TMO),
        .CNT_W   (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an instruction is either absent, in flight for m_el cycles, or has
    // its result waiting to be written back.
    typedef enum logic [1:0] {MIdle, MBusy, MResult} mph_e;
    mph_e       m_ph = MIdle;
    int         m_el = 0;
    logic [1:0] m_op = 2'b00;
    logic       e_start, e_stall, e_we, e_busy, e_tmo, fin;
    logic [6:0] exp_v;
    wire  [6:0] act = {bus.fpu_start, bus.fp_stall, bus.fp_res_we, bus.fpu_busy,
                       bus.fp_timeout, bus.fpu_op};

    always_comb begin
        e_start = 1'b0;
        e_stall = 1'b0;
        e_we    = 1'b0;
        e_busy  = 1'b0;
        e_tmo   = 1'b0;
        fin     = 1'b0;
        case (m_ph)
            MIdle: begin
                e_start = bus.fp_validE && !bus.flushE && !bus.mem_stall;
                e_stall = e_start;
            end
            MBusy: begin
                e_stall = 1'b1;
                e_busy  = 1'b1;
                if (m_op == 2'b11) begin
                    fin   = bus.fpu_done || (m_el == DIV_TMO);
                    e_tmo = (m_el == DIV_TMO) && !bus.fpu_done;
                end else begin
                    fin = (m_el == ((m_op == 2'b10) ? MUL_LAT : ADD_LAT) - 1);
                end
            end
            default: begin
                e_busy = 1'b1;
                e_we   = !bus.mem_stall;
            end
        endcase
    end

    assign exp_v = {e_start, e_stall, e_we, e_busy, e_tmo, m_op};

    always @(posedge clk) begin
        if (rst) begin
            m_ph <= MIdle;
            m_op <= 2'b00;
            m_el <= 0;
        end else begin
            case (m_ph)
                MIdle: if (e_start) begin
                    m_ph <= MBusy;
                    m_op <= bus.fp_opE;
                    m_el <= 1;
                end
                MBusy: if (fin) m_ph <= MResult; else m_el <= m_el + 1;
                default: if (!bus.mem_stall) m_ph <= MIdle;
            endcase
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (act !== 7'd0) begin
            n_err++;
            $display("FAIL reset outputs got=%b want=%b", act, 7'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int stalls = 0;
        int we_at = -1;
        int starts = 0;
        for (int c = 0; c < 6; c++) begin
            bus.fp_validE = (c == 0);
            bus.fp_opE    = FP_ADD;
            @(negedge clk);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL add c=%0d got=%b want=%b", c, act, exp_v);
            end
            stalls += int'(bus.fp_stall);
            starts += int'(bus.fpu_start);
            if (bus.fp_res_we) we_at = c;
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (stalls != ADD_LAT || we_at != ADD_LAT || starts != 1) begin
            n_err++;
            $display("FAIL add_timing stalls=%0d we_at=%0d starts=%0d want %0d/%0d/1",
                     stalls, we_at, starts, ADD_LAT, ADD_LAT);
        end
    endtask

    task automatic test_back_to_back();
        int start_c[$];
        int we_c[$];
        for (int c = 0; c < 11; c++) begin
            bus.fp_validE = (c == 0) || (c == 5);
            bus.fp_opE    = (c == 0) ? FP_MUL : FP_ADD;
            @(negedge clk);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL b2b c=%0d got=%b want=%b", c, act, exp_v);
            end
            if (bus.fpu_start) start_c.push_back(c);
            if (bus.fp_res_we) we_c.push_back(c);
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (start_c.size() != 2 || we_c.size() != 2 || start_c[1] != 5 || we_c[0] != 4
            || we_c[1] != 8) begin
            n_err++;
            $display("FAIL b2b_timing starts=%0d we=%0d want starts 0,5 we 4,8",
                     start_c.size(), we_c.size());
        end
    endtask

    task automatic test_div(input int done_at, input int ncyc, input int want_we,
                            input int want_tmo);
        int we_at = -1;
        int tmo_at = -1;
        for (int c = 0; c < ncyc; c++) begin
            bus.fp_validE = (c == 0);
            bus.fp_opE    = FP_DIV;
            bus.fpu_done  = (done_at >= 0) && (c >= done_at);
            @(negedge clk);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL div c=%0d got=%b want=%b", c, act, exp_v);
            end
            if (bus.fp_res_we) we_at = c;
            if (bus.fp_timeout) tmo_at = c;
            @(posedge clk);
            #1;
        end
        bus.fpu_done = 1'b0;
        n_vec++;
        if (we_at != want_we || tmo_at != want_tmo) begin
            n_err++;
            $display("FAIL div_timing we_at=%0d tmo_at=%0d want %0d/%0d",
                     we_at, tmo_at, want_we, want_tmo);
        end
    endtask

    task automatic test_mem_stall_done();
        int we_cnt = 0;
        int we_at = -1;
        for (int c = 0; c < 9; c++) begin
            bus.fp_validE = (c == 0);
            bus.fp_opE    = FP_ADD;
            bus.mem_stall = (c >= 3) && (c <= 5);
            @(negedge clk);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL mstall_done c=%0d got=%b want=%b", c, act, exp_v);
            end
            we_cnt += int'(bus.fp_res_we);
            if (bus.fp_res_we) we_at = c;
            if (c == 7) begin
                n_vec++;
                if (bus.fpu_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL mstall_idle_after got=%b want=0", bus.fpu_busy);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.mem_stall = 1'b0;
        n_vec++;
        if (we_cnt != 1 || we_at != 6) begin
            n_err++;
            $display("FAIL mstall_we cnt=%0d at=%0d want 1/6", we_cnt, we_at);
        end
    endtask

    task automatic test_mem_stall_idle();
        int first_start = -1;
        for (int c = 0; c < 10; c++) begin
            bus.fp_validE = (c <= 3);
            bus.fp_opE    = FP_SUB;
            bus.mem_stall = (c <= 2);
            @(negedge clk);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL mstall_idle c=%0d got=%b want=%b", c, act, exp_v);
            end
            if (bus.fpu_start && first_start < 0) first_start = c;
            @(posedge clk);
            #1;
        end
        bus.mem_stall = 1'b0;
        n_vec++;
        if (first_start != 3) begin
            n_err++;
            $display("FAIL mstall_defer start_at=%0d want 3", first_start);
        end
    endtask

    task automatic test_flush();
        int we_at = -1;
        for (int c = 0; c < 8; c++) begin
            bus.fp_validE = (c <= 1);
            bus.fp_opE    = FP_MUL;
            bus.flushE    = (c == 0) || (c == 2) || (c == 3);
            @(negedge clk);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL flush c=%0d got=%b want=%b", c, act, exp_v);
            end
            if (c == 0) begin
                n_vec++;
                if ({bus.fpu_start, bus.fp_stall} !== 2'b00) begin
                    n_err++;
                    $display("FAIL flush_block got=%b want=00", {bus.fpu_start, bus.fp_stall});
                end
            end
            if (bus.fp_res_we) we_at = c;
            @(posedge clk);
            #1;
        end
        bus.flushE = 1'b0;
        n_vec++;
        if (we_at != 1 + MUL_LAT) begin
            n_err++;
            $display("FAIL flush_run we_at=%0d want %0d", we_at, 1 + MUL_LAT);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int c = 0; c < 9; c++) begin
            rst           = (c == 2);
            bus.fp_validE = (c == 0) || (c == 3);
            bus.fp_opE    = (c == 0) ? FP_MUL : FP_ADD;
            @(negedge clk);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL rst_run c=%0d got=%b want=%b", c, act, exp_v);
            end
            if (c == 3) begin
                n_vec++;
                if (act !== 7'b1100000) begin
                    n_err++;
                    $display("FAIL rst_recover got=%b want=%b", act, 7'b1100000);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus.fp_validE = $urandom_range(0, 1) == 1;
            bus.fp_opE    = 2'($urandom_range(0, 3));
            bus.flushE    = ($urandom_range(0, 4) == 0);
            bus.mem_stall = ($urandom_range(0, 3) == 0);
            bus.fpu_done  = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            n_vec++;
            if (act !== exp_v) begin
                n_err++;
                $display("FAIL random c=%0d got=%b want=%b", c, act, exp_v);
            end
            @(posedge clk);
            #1;
        end
        rst           = 1'b0;
        bus.fp_validE = 1'b0;
        bus.flushE    = 1'b0;
        bus.mem_stall = 1'b0;
        bus.fpu_done  = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.fp_validE = 1'b0;
        bus.fp_opE    = 2'b00;
        bus.flushE    = 1'b0;
        bus.mem_stall = 1'b0;
        bus.fpu_done  = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_div(10, 14, 11, -1);
        test_div(-1, 68, DIV_TMO + 1, DIV_TMO);
        test_mem_stall_done();
        test_mem_stall_idle();
        test_flush();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
